// File: rtl/minterm_scan_ctrl.sv
// minterm_scan_ctrl: steps {a,b,c} through all 8 minterms and captures e/f truth maps.
// Optional SCAN_AUTO_RESTART_EN: loop scans continuously until abort or reset.
`default_nettype none

module minterm_scan_ctrl #(
  parameter int         SETTLE  = 2,
  parameter logic [7:0] EXP_MAP = 8'hD5
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       start,
  input  logic       abort,
  input  logic       d_level,
  input  logic       e_in,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] e_map,
  output logic [7:0] f_map
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       d_q, d_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] e_map_q, e_map_d;
  logic [7:0] f_map_q, f_map_d;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      abc_q   <= 3'd0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      e_map_q <= 8'h00;
      f_map_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      e_map_q <= e_map_d;
      f_map_q <= f_map_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    e_map_d = e_map_q;
    f_map_d = f_map_q;

    case (state_q)
      IDLE: begin
        if (abort) begin
          done_d = 1'b0;
          pass_d = 1'b0;
        end else if (start) begin
          d_d     = d_level;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          abc_d   = 3'd0;
          e_map_d = 8'h00;
          f_map_d = 8'h00;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = APPLY;
        end
      end

      APPLY, SAMPLE: begin
        if (abort) begin
          // Partial maps stay visible so an aborted scan can be inspected.
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          abc_d   = 3'd0;
          d_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (state_q == APPLY) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = 4'd0;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          e_map_d[idx_q] = e_in;
          f_map_d[idx_q] = f_in;
          if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            abc_d   = idx_q + 3'd1;
            cnt_d   = 4'd0;
            state_d = APPLY;
          end else begin
            done_d = 1'b1;
            pass_d = (e_map_d == EXP_MAP) && (f_map_d == (d_q ? EXP_MAP : 8'h00));
            idx_d  = 3'd0;
            cnt_d  = 4'd0;
            abc_d  = 3'd0;
`ifdef SCAN_AUTO_RESTART_EN
            e_map_d = 8'h00;
            f_map_d = 8'h00;
            d_d     = d_level;
            state_d = APPLY;
`else
            d_d     = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c} = abc_q;
  assign d         = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign e_map     = e_map_q;
  assign f_map     = f_map_q;

endmodule

`default_nettype wire

// File: tb/tb_minterm_scan_ctrl.sv
// Scoreboard bench for minterm_scan_ctrl driving a behavioural f=SUM(0,2,4,6,7) circuit.
`default_nettype none

module tb_minterm_scan_ctrl;
  localparam int SETTLE = 2;
  localparam int LAT    = 8 * (SETTLE + 1);

  logic       clock = 1'b0;
  logic       reset_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       d_level = 1'b0;
  logic       fault = 1'b0;
  logic       e_in, f_in;
  logic       a, b, c, d, busy, done, pass;
  logic [7:0] e_map, f_map;

  minterm_scan_ctrl #(.SETTLE(SETTLE), .EXP_MAP(8'hD5)) dut (
    .clock(clock), .reset_b(reset_b), .start(start), .abort(abort),
    .d_level(d_level), .e_in(e_in), .f_in(f_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
    .e_map(e_map), .f_map(f_map)
  );

  // Function circuit under test: minterms 0,2,4,6,7; fault forces minterm 7 low.
  logic [7:0] truth = 8'hD5;
  always_comb begin
    e_in = truth[{a, b, c}];
    if (fault && ({a, b, c} == 3'd7)) e_in = 1'b0;
    f_in = e_in & d;
  end

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         done_cyc;
    logic [7:0] e;
    logic [7:0] f;
    logic       p;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  logic prev_done = 1'b0;

  always @(negedge clock) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_x = sb.pop_front();
        chk("done_latency", cyc, mon_x.done_cyc);
        chk("e_map", {24'd0, e_map}, {24'd0, mon_x.e});
        chk("f_map", {24'd0, f_map}, {24'd0, mon_x.f});
        chk("pass", {31'd0, pass}, {31'd0, mon_x.p});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("abcd_at_done", {28'd0, a, b, c, d}, 32'd0);
      end
    end
    prev_done = done;
  end

  task automatic launch(input logic dl, input logic flt, input logic [7:0] ee,
                        input logic [7:0] ff, input logic p);
    exp_t x;
    @(negedge clock);
    fault   = flt;
    d_level = dl;
    start   = 1'b1;
    x.done_cyc = cyc + 1 + LAT;
    x.e = ee;
    x.f = ff;
    x.p = p;
    sb.push_back(x);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (!busy) seen = 1'b1;
    end
    if (!seen) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_pass", {30'd0, done, pass}, 32'd0);
    chk("rst_abcd", {28'd0, a, b, c, d}, 32'd0);
    chk("rst_maps", {16'd0, e_map, f_map}, 32'd0);
    reset_b = 1'b1;

    // Good circuit, d=1 and d=0; then faulty circuit.
    launch(1'b1, 1'b0, 8'hD5, 8'hD5, 1'b1);
    wait_idle();
    launch(1'b0, 1'b0, 8'hD5, 8'h00, 1'b1);
    wait_idle();
    launch(1'b1, 1'b1, 8'h55, 8'h55, 1'b0);
    wait_idle();

    // Abort in IDLE clears done/pass but keeps maps.
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    chk("idle_abort_done_pass", {30'd0, done, pass}, 32'd0);
    chk("idle_abort_maps_kept", {24'd0, e_map}, 32'h55);

    // Re-pulsed start mid-scan is ignored; d stays latched at 1.
    launch(1'b1, 1'b0, 8'hD5, 8'hD5, 1'b1);
    repeat (3) @(negedge clock);
    d_level = 1'b0;
    start   = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("d_latched_mid_scan", {31'd0, d}, 32'd1);
    wait_idle();

    // Abort and start together in IDLE: abort wins.
    @(negedge clock); start = 1'b1; abort = 1'b1;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", {31'd0, busy}, 32'd0);
    chk("abort_beats_start_done", {31'd0, done}, 32'd0);

    // Abort while idx=3.
    @(negedge clock); d_level = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if ({a, b, c} == 3'd3) found = 1'b1;
      else @(negedge clock);
    end
    chk("reach_idx3", {31'd0, found}, 32'd1);
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    chk("abort_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
    chk("abort_abcd", {28'd0, a, b, c, d}, 32'd0);
    chk("abort_e_map_partial", {24'd0, e_map}, 32'h05);
    chk("abort_f_map_partial", {24'd0, f_map}, 32'h05);

    // Asynchronous reset mid-scan.
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset_b = 1'b0;
    #1;
    chk("async_rst_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
    chk("async_rst_abcd", {28'd0, a, b, c, d}, 32'd0);
    chk("async_rst_maps", {16'd0, e_map, f_map}, 32'd0);
    @(negedge clock); reset_b = 1'b1;
    repeat (30) @(negedge clock);
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
